opsum_ppu: RTL and testbench
============================

OPSUM_PPU -- requirements
Module: opsum_ppu

Interface
REQ-001 SHALL take parameters: DATA_SIZE, default `DATA_BITS (32), signed opsum width; ADDR_SIZE, default 32, GLB byte-address width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  launch one job from IDLE
- cfg_total  in  16  number of opsums in the job
- cfg_base_addr  in  ADDR_SIZE  first GLB word address (byte address, 4-aligned)
- cfg_scale  in  16  unsigned requant multiplier
- cfg_shift  in  5  requant right shift
- cfg_zp  in  8  signed output zero point
- cfg_relu  in  1  runtime ReLU select (see Configuration)
- opsum_valid  in  1  PE_array GLB_opsum_valid
- opsum_ready  out  1  to PE_array GLB_opsum_ready
- opsum_data  in  DATA_SIZE  PE_array GLB_data_out
- glb_wvalid  out  1  GLB write request
- glb_wready  in  1  GLB write accept
- glb_addr  out  ADDR_SIZE  write address
- glb_wdata  out  32  four packed int8 results
- glb_wstrb  out  4  byte-lane enables
- busy  out  1  high in RUN or FLUSH
- done  out  1  one-cycle pulse at job end
REQ-003 Config inputs SHALL be sampled into internal registers on the cycle start is taken; later changes SHALL have no effect on the running job.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
- IDLE->RUN: start=1 and cfg_total!=0.
- IDLE->DONE: start=1 and cfg_total==0.
- RUN->FLUSH: last opsum accepted.
- FLUSH->DONE: last word handshaked.
- DONE->IDLE: unconditionally, after one cycle.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 An opsum transfer SHALL occur on opsum_valid && opsum_ready.
- opsum_ready=1 only in RUN, while accepted count < total, and while the pipeline can advance.
REQ-007 Pipeline stages:
- Stage 1 (register): prod = signed(opsum_data) * unsigned(cfg_scale), 48-bit signed.
- Stage 2:
  - If shift>0, add 2^(shift-1) before the arithmetic right shift, else pass through.
  - Add sign-extended zp.
  - Saturate to [-128,127].
REQ-008 A result SHALL occupy byte lane (index mod 4) of the pack register, two cycles after its transfer, absent stall.
REQ-009 A word SHALL be moved to the output register when lane 3 is written or the job's final element is written.
- glb_wstrb = lanes written; unwritten lanes are 0.
REQ-010 glb_addr SHALL equal base for the first word and increment by 4 per word handshake.
REQ-011 Once glb_wvalid is asserted, glb_wvalid/addr/wdata/wstrb SHALL stay stable until glb_wready.
REQ-012 When the output register is full and glb_wready=0, the whole pipeline SHALL stall, opsum_ready=0, and no data SHALL be lost or duplicated.
- A handshake and a new word in the same cycle SHALL be allowed, giving zero-bubble streaming.
REQ-013 Accept/element counters SHALL be 16-bit; cfg_total=65535 SHALL complete with exactly 16384 words.
REQ-014 done SHALL pulse exactly one cycle in DONE; busy SHALL be 0 in IDLE and DONE.

Reset
REQ-015 On rst, state=IDLE, all counters, pipeline valids and pack lanes cleared.
- Outputs opsum_ready, glb_wvalid, glb_addr, glb_wdata, glb_wstrb, busy, done = 0.
REQ-016 rst asserted mid-job SHALL abort it immediately: no done pulse and no further writes.

Configuration
REQ-017 Macro OPSUM_PPU_RELU_EN:
- Defined: when cfg_relu=1, values below zero after the shift SHALL be forced to 0 before the zp add.
- Undefined: cfg_relu is present but ignored; no ReLU logic is synthesized.

Verification
REQ-018 total=4, base=0x100, scale=1, shift=0, zp=0, opsums 1,-2,127,200 -> one write: addr 0x100, wdata 0x7F7FFE01, wstrb 0xF, then done.
REQ-019 total=5, scale=3, shift=1, opsums all 5 -> words at base and base+4.
- First word wdata 0x08080808, wstrb 0xF.
- Second word wdata 0x00000008, wstrb 0x1.
REQ-020 glb_wready held 0 for 10 cycles mid-job -> opsum_ready=0 within 2 cycles, output stable, all 8 results later written once, in order.
REQ-021 total=0 with start -> done pulses 2 cycles after start, no glb_wvalid.
REQ-022 With OPSUM_PPU_RELU_EN, cfg_relu=1, zp=10, opsum -50 -> byte 0x0A; without the macro -> byte 0xD8 (-40).
REQ-023 rst pulsed after 3 of 8 opsums -> outputs 0 next cycle; a new start runs cleanly from base.

Source files
------------

// File: rtl/opsum_ppu.sv
// opsum_ppu: requantizes PE-array opsums to int8, packs four results per
// 32-bit word and writes the words to the GLB at consecutive addresses.
// Optional feature macro: OPSUM_PPU_RELU_EN (runtime ReLU via cfg_relu).
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module opsum_ppu #(
   parameter int DATA_SIZE = `DATA_BITS,
   parameter int ADDR_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          cfg_total,
   input  logic [ADDR_SIZE-1:0] cfg_base_addr,
   input  logic [15:0]          cfg_scale,
   input  logic [4:0]           cfg_shift,
   input  logic [7:0]           cfg_zp,
   input  logic                 cfg_relu,
   input  logic                 opsum_valid,
   output logic                 opsum_ready,
   input  logic [DATA_SIZE-1:0] opsum_data,
   output logic                 glb_wvalid,
   input  logic                 glb_wready,
   output logic [ADDR_SIZE-1:0] glb_addr,
   output logic [31:0]          glb_wdata,
   output logic [3:0]           glb_wstrb,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [15:0]           r_total;
   logic [15:0]           r_scale;
   logic [4:0]            r_shift;
   logic signed [7:0]     r_zp;
   logic [15:0]           r_acc_cnt;
   logic [15:0]           r_elem_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_s1_valid;
   logic signed [47:0]    r_s1_prod;
   logic [31:0]           r_pack;
   logic [3:0]            r_pack_strb;
   logic                  r_wvalid;
   logic [ADDR_SIZE-1:0]  r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_out_last;
`ifdef OPSUM_PPU_RELU_EN
   logic                  r_relu;
`else
   logic                  w_unused_relu;
   assign w_unused_relu = cfg_relu;
`endif

   logic                  w_start;
   logic                  w_hs;
   logic                  w_adv;
   logic                  w_xfer;
   logic signed [47:0]    w_op_ext;
   logic signed [47:0]    w_scale_ext;
   logic signed [47:0]    w_prod;
   logic signed [48:0]    w_round;
   logic signed [48:0]    w_shifted;
   logic signed [48:0]    w_relu;
   logic signed [49:0]    w_biased;
   logic [7:0]            w_byte;
   logic [1:0]            w_lane;
   logic                  w_s2_last;
   logic [31:0]           w_word;
   logic [3:0]            w_word_strb;

   // The whole pipeline only moves when the output register can take a word.
   assign w_start     = (r_state == S_IDLE) && start;
   assign w_hs        = r_wvalid && glb_wready;
   assign w_adv       = !r_wvalid || glb_wready;
   assign opsum_ready = (r_state == S_RUN) && (r_acc_cnt < r_total) && w_adv;
   assign w_xfer      = opsum_valid && opsum_ready;

   assign w_op_ext    = {{(48-DATA_SIZE){opsum_data[DATA_SIZE-1]}}, opsum_data};
   assign w_scale_ext = {32'd0, r_scale};
   assign w_prod      = w_op_ext * w_scale_ext;

   assign glb_wvalid  = r_wvalid;
   assign glb_addr    = r_addr;
   assign glb_wdata   = r_wdata;
   assign glb_wstrb   = r_wstrb;
   assign busy        = r_busy;
   assign done        = r_done;

   // Stage 2: round, shift, optional ReLU, zero-point add, saturate and merge into the pack word.
   always_comb begin
      w_round = '0;
      if (r_shift != 5'd0) begin
         w_round = 49'sd1 <<< (r_shift - 5'd1);
      end else begin
         w_round = '0;
      end
      w_shifted = ($signed({r_s1_prod[47], r_s1_prod}) + w_round) >>> r_shift;
`ifdef OPSUM_PPU_RELU_EN
      if (r_relu && (w_shifted < 49'sd0)) begin
         w_relu = '0;
      end else begin
         w_relu = w_shifted;
      end
`else
      w_relu = w_shifted;
`endif
      w_biased = {w_relu[48], w_relu} + {{42{r_zp[7]}}, r_zp};
      if (w_biased > 50'sd127) begin
         w_byte = 8'h7F;
      end else if (w_biased < -50'sd128) begin
         w_byte = 8'h80;
      end else begin
         w_byte = w_biased[7:0];
      end
      w_lane      = r_elem_cnt[1:0];
      w_s2_last   = (r_elem_cnt == (r_total - 16'd1));
      w_word      = r_pack;
      w_word_strb = r_pack_strb | (4'd1 << w_lane);
      case (w_lane)
         2'd0:    w_word[7:0]   = w_byte;
         2'd1:    w_word[15:8]  = w_byte;
         2'd2:    w_word[23:16] = w_byte;
         2'd3:    w_word[31:24] = w_byte;
         default: w_word        = r_pack;
      endcase
   end

   // Job control FSM: captures the configuration on start and sequences RUN/FLUSH/DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_total   <= 16'd0;
         r_scale   <= 16'd0;
         r_shift   <= 5'd0;
         r_zp      <= 8'sd0;
         r_acc_cnt <= 16'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef OPSUM_PPU_RELU_EN
         r_relu    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_total   <= cfg_total;
                  r_scale   <= cfg_scale;
                  r_shift   <= cfg_shift;
                  r_zp      <= cfg_zp;
                  r_acc_cnt <= 16'd0;
`ifdef OPSUM_PPU_RELU_EN
                  r_relu    <= cfg_relu;
`endif
                  if (cfg_total != 16'd0) begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_acc_cnt <= r_acc_cnt + 16'd1;
                  if (r_acc_cnt == (r_total - 16'd1)) begin
                     r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (w_hs && r_out_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: multiply stage, lane packing and the held-until-accepted output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_prod   <= 48'sd0;
         r_elem_cnt  <= 16'd0;
         r_pack      <= 32'd0;
         r_pack_strb <= 4'd0;
         r_wvalid    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_wstrb     <= 4'd0;
         r_out_last  <= 1'b0;
      end else if (w_start) begin
         r_s1_valid  <= 1'b0;
         r_elem_cnt  <= 16'd0;
         r_pack      <= 32'd0;
         r_pack_strb <= 4'd0;
         r_wvalid    <= 1'b0;
         r_addr      <= cfg_base_addr;
         r_out_last  <= 1'b0;
      end else begin
         if (w_hs) begin
            r_wvalid <= 1'b0;
            r_addr   <= r_addr + ADDR_SIZE'(4);
         end
         if (w_adv) begin
            r_s1_valid <= w_xfer;
            r_s1_prod  <= w_prod;
            if (r_s1_valid) begin
               r_elem_cnt <= r_elem_cnt + 16'd1;
               if ((w_lane == 2'd3) || w_s2_last) begin
                  r_wvalid    <= 1'b1;
                  r_wdata     <= w_word;
                  r_wstrb     <= w_word_strb;
                  r_out_last  <= w_s2_last;
                  r_pack      <= 32'd0;
                  r_pack_strb <= 4'd0;
               end else begin
                  r_pack      <= w_word;
                  r_pack_strb <= w_word_strb;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_opsum_ppu.sv
// tb_opsum_ppu: table vectors, directed corner sequences and randomized jobs
// for opsum_ppu, checked against an arithmetic requantization model.
`timescale 1ns/1ps

module tb_opsum_ppu;

`ifdef OPSUM_PPU_RELU_EN
   localparam bit RELU_BUILT = 1'b1;
`else
   localparam bit RELU_BUILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] cfg_total;
   logic [31:0] cfg_base_addr;
   logic [15:0] cfg_scale;
   logic [4:0]  cfg_shift;
   logic [7:0]  cfg_zp;
   logic        cfg_relu;
   logic        opsum_valid;
   logic        opsum_ready;
   logic [31:0] opsum_data;
   logic        glb_wvalid;
   logic        glb_wready;
   logic [31:0] glb_addr;
   logic [31:0] glb_wdata;
   logic [3:0]  glb_wstrb;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   opsum_ppu #(.DATA_SIZE(32), .ADDR_SIZE(32)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_total(cfg_total),
      .cfg_base_addr(cfg_base_addr), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
      .cfg_zp(cfg_zp), .cfg_relu(cfg_relu), .opsum_valid(opsum_valid),
      .opsum_ready(opsum_ready), .opsum_data(opsum_data), .glb_wvalid(glb_wvalid),
      .glb_wready(glb_wready), .glb_addr(glb_addr), .glb_wdata(glb_wdata),
      .glb_wstrb(glb_wstrb), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   typedef struct {
      int          total;
      int          scale;
      int          shift;
      int          zp;
      bit          relu;
      int          d0, d1, d2, d3;
      logic [31:0] exp_data;
      logic [3:0]  exp_strb;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   ops[$];
   wr_t  got[$];
   wr_t  exp_q[$];
   vec_t vt[6];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Requantization straight from the arithmetic rules.
   function automatic logic [7:0] ref_byte(input int op, input int scale, input int shift,
                                           input int zp, input bit relu);
      longint v;
      v = longint'(op) * longint'(scale);
      if (shift > 0) v = (v + (longint'(1) << (shift - 1))) >>> shift;
      if (relu && RELU_BUILT && v < 0) v = 0;
      v = v + longint'(zp);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   task automatic run_job(input string tag, input int total, input logic [31:0] base,
                          input int scale, input int shift, input int zp, input bit relu,
                          input int mode);
      int  idx = 0;
      int  cycles = 1;
      int  budget;
      int  stall_left = 0;
      bit  stall_used = 1'b0;
      bit  prev_hold = 1'b0;
      bit  fin = 1'b0;
      wr_t prev;
      wr_t e;
      logic [31:0] d;
      got.delete();
      exp_q.delete();
      for (int w = 0; w < (total + 3) / 4; w++) begin
         d = 32'd0;
         e.strb = 4'd0;
         for (int l = 0; l < 4; l++) begin
            if (4 * w + l < total) begin
               d[8*l +: 8] = ref_byte(ops[4*w+l], scale, shift, zp, relu);
               e.strb[l] = 1'b1;
            end
         end
         e.addr = base + 32'(4 * w);
         e.data = d;
         exp_q.push_back(e);
      end
      budget = (mode == 0) ? total + 40 : 4 * total + 100;
      @(negedge clk);
      cfg_total = 16'(total); cfg_base_addr = base; cfg_scale = 16'(scale);
      cfg_shift = 5'(shift); cfg_zp = 8'(zp); cfg_relu = relu;
      start = 1'b1; opsum_valid = 1'b0; glb_wready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_total = 16'($urandom); cfg_base_addr = $urandom; cfg_scale = 16'($urandom);
      cfg_shift = 5'($urandom); cfg_zp = 8'($urandom); cfg_relu = 1'($urandom);
      while (!fin && cycles < budget) begin
         case (mode)
            0: glb_wready = 1'b1;
            1: glb_wready = ($urandom_range(0, 99) < 70);
            2: begin
               if (!stall_used && glb_wvalid) begin
                  stall_used = 1'b1;
                  stall_left = 10;
               end
               glb_wready = (stall_left == 0);
            end
            default: glb_wready = 1'b1;
         endcase
         if (idx < total) begin
            opsum_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 80);
            opsum_data  = ops[idx];
         end else begin
            opsum_valid = 1'b0;
            opsum_data  = $urandom;
         end
         #1;
         if (cycles == 1) chk({tag, " busy"}, busy, 1'b1);
         if (stall_left > 0) begin
            if (stall_left == 8) chk({tag, " stall ready"}, opsum_ready, 1'b0);
            stall_left--;
         end
         if (prev_hold) chk({tag, " hold"}, {glb_wvalid, glb_addr, glb_wdata, glb_wstrb}, {1'b1, prev});
         prev_hold = glb_wvalid && !glb_wready;
         prev = {glb_addr, glb_wdata, glb_wstrb};
         if (opsum_valid && opsum_ready) idx++;
         if (glb_wvalid && glb_wready) got.push_back({glb_addr, glb_wdata, glb_wstrb});
         if (done) fin = 1'b1;
         @(negedge clk);
         cycles++;
      end
      opsum_valid = 1'b0;
      chk({tag, " done seen"}, fin, 1'b1);
      if (!fin) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
      chk({tag, " idle after"}, {done, busy, glb_wvalid}, 3'b000);
      chk({tag, " word count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s word%0d", tag, i), got[i], exp_q[i]);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_done;
      int done_cnt;
      bit wv_seen;
      bit stray;
      rst = 1'b1; start = 1'b0; cfg_total = 16'd0; cfg_base_addr = 32'd0;
      cfg_scale = 16'd0; cfg_shift = 5'd0; cfg_zp = 8'd0; cfg_relu = 1'b0;
      opsum_valid = 1'b0; opsum_data = 32'd0; glb_wready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {opsum_ready, glb_wvalid, glb_addr, glb_wdata, glb_wstrb, busy, done}, 72'd0);
      rst = 1'b0;

      // Table vectors: single-word jobs with hand-computed words.
      vt[0] = '{4, 1, 0, 0, 1'b0, 1, -2, 127, 200, 32'h7F7FFE01, 4'hF};
`ifdef OPSUM_PPU_RELU_EN
      vt[1] = '{1, 1, 0, 10, 1'b1, -50, 0, 0, 0, 32'h0000000A, 4'h1};
      vt[5] = '{2, 1, 0, 0, 1'b1, -3, 3, 0, 0, 32'h00000300, 4'h3};
`else
      vt[1] = '{1, 1, 0, 10, 1'b1, -50, 0, 0, 0, 32'h000000D8, 4'h1};
      vt[5] = '{2, 1, 0, 0, 1'b1, -3, 3, 0, 0, 32'h000003FD, 4'h3};
`endif
      vt[2] = '{3, 2, 2, -5, 1'b0, 10, -10, -1000, 0, 32'h0080F600, 4'h7};
      vt[3] = '{2, 65535, 16, 0, 1'b0, 100, -100, 0, 0, 32'h00009C64, 4'h3};
      vt[4] = '{4, 1, 0, 127, 1'b0, 0, 1, -128, -255, 32'h80FF7F7F, 4'hF};
      for (int i = 0; i < 6; i++) begin
         ops.delete();
         ops.push_back(vt[i].d0); ops.push_back(vt[i].d1);
         ops.push_back(vt[i].d2); ops.push_back(vt[i].d3);
         while (ops.size() > vt[i].total) void'(ops.pop_back());
         run_job($sformatf("vec%0d", i), vt[i].total, 32'h100 + 32'(64 * i), vt[i].scale,
                 vt[i].shift, vt[i].zp, vt[i].relu, 0);
         if (got.size() > 0)
            chk($sformatf("vec%0d table", i), got[0], {32'h100 + 32'(64 * i), vt[i].exp_data, vt[i].exp_strb});
         else
            chk($sformatf("vec%0d table", i), 72'd0, 72'd1);
      end

      // Partial final word: five opsums over two words.
      ops.delete();
      repeat (5) ops.push_back(5);
      run_job("two words", 5, 32'h400, 3, 1, 0, 1'b0, 1);
      if (got.size() == 2) begin
         chk("two words w0", got[0], {32'h400, 32'h08080808, 4'hF});
         chk("two words w1", got[1], {32'h404, 32'h00000008, 4'h1});
      end else begin
         chk("two words size", got.size(), 2);
      end

      // Ten-cycle write back-pressure in the middle of an eight-opsum job.
      ops.delete();
      for (int i = 0; i < 8; i++) ops.push_back(int'($urandom_range(0, 600)) - 300);
      run_job("stall", 8, 32'h800, 7, 3, -2, 1'b0, 2);

      // Empty job: done pulse only, no writes.
      @(negedge clk);
      cfg_total = 16'd0; cfg_base_addr = 32'hA00; start = 1'b1; glb_wready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      first_done = 0; done_cnt = 0; wv_seen = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (done) begin
            done_cnt++;
            if (first_done == 0) first_done = k;
         end
         if (glb_wvalid) wv_seen = 1'b1;
         @(negedge clk);
      end
      chk("empty done timing", (first_done >= 1 && first_done <= 2), 1'b1);
      chk("empty done width", done_cnt, 1);
      chk("empty no write", wv_seen, 1'b0);

      // Reset mid-job after three accepted opsums, then a clean restart.
      ops.delete();
      for (int i = 0; i < 8; i++) ops.push_back(i + 1);
      cfg_total = 16'd8; cfg_base_addr = 32'h2000; cfg_scale = 16'd1; cfg_shift = 5'd0;
      cfg_zp = 8'd0; cfg_relu = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int acc = 0;
         for (int c = 0; c < 20 && acc < 3; c++) begin
            opsum_valid = 1'b1; opsum_data = ops[acc];
            #1;
            if (opsum_ready) acc++;
            @(negedge clk);
         end
         chk("abort accepted", acc, 3);
      end
      opsum_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort outputs", {opsum_ready, glb_wvalid, glb_addr, glb_wdata, glb_wstrb, busy, done}, 72'd0);
      @(negedge clk);
      rst = 1'b0;
      stray = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (glb_wvalid || done || busy) stray = 1'b1;
      end
      chk("abort quiet", stray, 1'b0);
      run_job("restart", 8, 32'h3000, 1, 0, 0, 1'b0, 1);

      // Randomized jobs.
      for (int j = 0; j < 6; j++) begin
         int t;
         t = $urandom_range(1, 40);
         ops.delete();
         for (int i = 0; i < t; i++)
            ops.push_back((j % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000);
         run_job($sformatf("rand%0d", j), t, 32'h5000 + 32'(256 * j), $urandom_range(0, 65535),
                 $urandom_range(0, 31), int'($urandom_range(0, 255)) - 128, 1'($urandom), 1);
      end

      // Maximum-length job streamed without bubbles.
      ops.delete();
      for (int i = 0; i < 65535; i++) ops.push_back(int'($urandom_range(0, 511)) - 256);
      run_job("max", 65535, 32'h10000, 1, 1, 3, 1'b0, 0);
      chk("max words", got.size(), 16384);
      if (got.size() > 0) chk("max last strb", got[got.size()-1].strb, 4'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
